// File: rtl/rmt_axis_rr_arbiter_if.sv
// AXI-Stream bundle for the round-robin arbiter: NUM_PORTS flattened ingress lanes plus one egress lane.
// The "slave" modport is the arbiter's view and the "master" modport is the traffic side (sources and sink).
interface rmt_axis_rr_arbiter_if #(
  parameter int NUM_PORTS            = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
);
  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata;
  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0] s_axis_tkeep;
  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser;
  logic [NUM_PORTS-1:0]                         s_axis_tvalid;
  logic [NUM_PORTS-1:0]                         s_axis_tlast;
  logic [NUM_PORTS-1:0]                         s_axis_tready;

  logic [C_S_AXIS_DATA_WIDTH-1:0]               m_axis_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser;
  logic                                         m_axis_tvalid;
  logic                                         m_axis_tlast;
  logic                                         m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/rmt_axis_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream ingress lanes into one egress lane.
// A granted port owns the output until its tlast beat transfers; per-port packet counters for status.
module rmt_axis_rr_arbiter #(
  parameter int NUM_PORTS            = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PORT_ID_WIDTH        = 2,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                           clk,
  input  logic                           aresetn,
  rmt_axis_rr_arbiter_if.slave           axis,
  output logic [PORT_ID_WIDTH-1:0]       grant_id,
  output logic                           busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [PORT_ID_WIDTH:0]   NP_EXT    = (PORT_ID_WIDTH+1)'(NUM_PORTS);
  localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT = PORT_ID_WIDTH'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_ID_WIDTH-1:0] grant_q, grant_d;
  logic [PORT_ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0]     cnt_d [NUM_PORTS];

  logic [PORT_ID_WIDTH-1:0] sel;
  logic                     sel_ok;
  logic                     sel_last;
  logic                     m_valid;
  logic                     xfer;

  function automatic logic [PORT_ID_WIDTH-1:0] next_port(input logic [PORT_ID_WIDTH-1:0] p);
    return (p == LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  // In IDLE the search restarts every cycle from rr_ptr, so a request that is not yet accepted can be overtaken.
  always_comb begin
    logic [PORT_ID_WIDTH:0] cand;
    sel    = '0;
    sel_ok = 1'b0;
    cand   = '0;
    if (state_q == LOCK) begin
      sel    = grant_q;
      sel_ok = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = {1'b0, rr_ptr_q} + (PORT_ID_WIDTH+1)'(k);
        if (cand >= NP_EXT) cand = cand - NP_EXT;
        if (!sel_ok && axis.s_axis_tvalid[cand[PORT_ID_WIDTH-1:0]]) begin
          sel    = cand[PORT_ID_WIDTH-1:0];
          sel_ok = 1'b1;
        end
      end
    end
  end

  // Zero-latency data path; aresetn gates the handshake so nothing leaks out while reset is held.
  always_comb begin
    m_valid  = aresetn && sel_ok && axis.s_axis_tvalid[sel];
    sel_last = axis.s_axis_tlast[sel];
    xfer     = m_valid && axis.m_axis_tready;

    axis.m_axis_tvalid = m_valid;
    axis.m_axis_tlast  = m_valid && sel_last;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tkeep  = '0;
    axis.m_axis_tuser  = '0;
    if (m_valid) begin
      axis.m_axis_tdata = axis.s_axis_tdata[int'(sel)*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
      axis.m_axis_tkeep = axis.s_axis_tkeep[int'(sel)*KW +: KW];
      axis.m_axis_tuser = axis.s_axis_tuser[int'(sel)*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
    end

    axis.s_axis_tready = '0;
    if (aresetn && sel_ok) axis.s_axis_tready[sel] = axis.m_axis_tready;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          grant_id_d = sel;
          if (sel_last) begin
            rr_ptr_d = next_port(sel);
          end else begin
            state_d = LOCK;
            grant_d = sel;
          end
        end
      end
      LOCK: begin
        if (xfer && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_port(grant_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer && sel_last) cnt_d[sel] = cnt_q[sel] + 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == LOCK);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_rmt_axis_rr_arbiter.sv
// Directed bench for rmt_axis_rr_arbiter: per-port packet sources, a rule-level reference model
// checked every cycle, and hand-computed beat orderings and counter values for each scenario.
module tb_rmt_axis_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int PW = 2;
  localparam int CW = 4;

  typedef struct {
    byte unsigned dByte;
    bit           last;
    int           gap;
    logic [15:0]  tag;
  } beat_t;

  typedef struct {
    logic [15:0] tag;
    logic [7:0]  dByte;
    bit          busy;
    int          gid;
    int          cyc;
  } obs_t;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [PW-1:0] grant_id;
  logic          busy;
  logic [NP*CW-1:0] pkt_cnt;

  rmt_axis_rr_arbiter_if #(
    .NUM_PORTS(NP), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)
  ) bus ();

  rmt_axis_rr_arbiter #(
    .NUM_PORTS(NP), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
    .PORT_ID_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .axis(bus),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int    passCnt = 0;
  int    totalCnt = 0;
  int    cycle = 0;
  beat_t srcQ [NP][$];
  int    idleCnt [NP];
  bit    acc [NP];
  bit    readySched [$];
  obs_t  obsLog [$];

  int mPtr, mLocked, mOwner, mGid;
  int mCnt [NP];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
  endtask

  task automatic applyStimulus(input int port, input int nBeats, input int pkt,
                               input int gapBeat, input int gapLen, input byte unsigned firstByte);
    beat_t b;
    for (int i = 0; i < nBeats; i++) begin
      b.dByte = firstByte - 8'(16 * i);
      b.last  = (i == nBeats - 1);
      b.gap   = (i == gapBeat) ? gapLen : 0;
      b.tag   = {8'(port), 4'(pkt), 4'(i)};
      srcQ[port].push_back(b);
    end
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    bit done = 1'b0;
    for (int n = 0; n < maxCycles && !done; n++) begin
      @(negedge clk); #2;
      done = (mLocked == 0) && (readySched.size() == 0);
      for (int i = 0; i < NP; i++) if (srcQ[i].size() != 0) done = 1'b0;
    end
    if (!done) begin
      totalCnt++;
      $display("[TB] FAIL %s drain timeout after %0d cycles", name, maxCycles);
    end
  endtask

  task automatic checkTags(input string name, input logic [15:0] expTags[$]);
    checkOutput({name, "_nbeats"}, DW'(obsLog.size()), DW'(expTags.size()));
    for (int i = 0; i < expTags.size() && i < obsLog.size(); i++)
      checkOutput($sformatf("%s_tag%0d", name, i), DW'(obsLog[i].tag), DW'(expTags[i]));
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    aresetn = 1'b0;
    readySched.delete();
    for (int i = 0; i < NP; i++) srcQ[i].delete();
    repeat (2) @(negedge clk);
    #2 aresetn = 1'b1;
    obsLog.delete();
  endtask

  // Sources: handshakes sampled at negedge, queues advanced and lanes redriven just after posedge.
  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < NP; i++) idleCnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) acc[i] = bus.s_axis_tvalid[i] & bus.s_axis_tready[i];
      @(posedge clk); #1;
      if (!aresetn) begin
        readySched.delete();
        for (int i = 0; i < NP; i++) begin
          srcQ[i].delete();
          idleCnt[i] = 0;
        end
      end else begin
        for (int i = 0; i < NP; i++)
          if (acc[i] && srcQ[i].size() > 0) begin
            void'(srcQ[i].pop_front());
            idleCnt[i] = 0;
          end
      end
      for (int i = 0; i < NP; i++) begin
        if (srcQ[i].size() > 0 && idleCnt[i] >= srcQ[i][0].gap) begin
          bus.s_axis_tvalid[i] = 1'b1;
          bus.s_axis_tlast[i]  = srcQ[i][0].last;
          bus.s_axis_tdata[i*DW +: DW] = {KW{srcQ[i][0].dByte}};
          bus.s_axis_tkeep[i*KW +: KW] = {8{srcQ[i][0].tag[7:0]}};
          bus.s_axis_tuser[i*UW +: UW] = {8{srcQ[i][0].tag}};
        end else begin
          if (srcQ[i].size() > 0) idleCnt[i]++;
          bus.s_axis_tvalid[i] = 1'b0;
          bus.s_axis_tlast[i]  = 1'b1;
          bus.s_axis_tdata[i*DW +: DW] = {KW{8'hA5}};
          bus.s_axis_tkeep[i*KW +: KW] = {KW{1'b1}};
          bus.s_axis_tuser[i*UW +: UW] = {UW{1'b1}};
        end
      end
      bus.m_axis_tready = (readySched.size() > 0) ? readySched.pop_front() : 1'b1;
    end
  end

  // Reference model: rules applied to plain integers, compared at every negedge, advanced at posedge.
  initial begin
    int sel;
    bit found, expValid, expLast, snapReady;
    logic [NP-1:0] expTready;
    logic [NP*CW-1:0] expCnt;
    obs_t o;
    mPtr = 0; mLocked = 0; mOwner = 0; mGid = 0;
    for (int i = 0; i < NP; i++) mCnt[i] = 0;
    forever begin
      @(negedge clk);
      cycle++;
      sel = 0;
      found = 1'b0;
      if (!aresetn) begin
        mPtr = 0; mLocked = 0; mOwner = 0; mGid = 0;
        for (int i = 0; i < NP; i++) mCnt[i] = 0;
      end else if (mLocked != 0) begin
        sel = mOwner;
        found = 1'b1;
      end else begin
        for (int k = 0; k < NP; k++)
          if (!found && bus.s_axis_tvalid[(mPtr + k) % NP]) begin
            sel = (mPtr + k) % NP;
            found = 1'b1;
          end
      end
      expValid  = found && bus.s_axis_tvalid[sel];
      expLast   = expValid && bus.s_axis_tlast[sel];
      expTready = '0;
      if (found) expTready[sel] = bus.m_axis_tready;
      for (int i = 0; i < NP; i++) expCnt[i*CW +: CW] = CW'(mCnt[i]);

      checkOutput("m_tvalid", DW'(bus.m_axis_tvalid), DW'(expValid));
      checkOutput("m_tlast", DW'(bus.m_axis_tlast), DW'(expLast));
      checkOutput("m_tdata", bus.m_axis_tdata, expValid ? bus.s_axis_tdata[sel*DW +: DW] : '0);
      checkOutput("m_tkeep", DW'(bus.m_axis_tkeep), expValid ? DW'(bus.s_axis_tkeep[sel*KW +: KW]) : '0);
      checkOutput("m_tuser", DW'(bus.m_axis_tuser), expValid ? DW'(bus.s_axis_tuser[sel*UW +: UW]) : '0);
      checkOutput("s_tready", DW'(bus.s_axis_tready), DW'(expTready));
      checkOutput("busy", DW'(busy), DW'(mLocked));
      checkOutput("grant_id", DW'(grant_id), DW'(mGid));
      checkOutput("pkt_cnt", DW'(pkt_cnt), DW'(expCnt));

      snapReady = bus.m_axis_tready;
      if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
        o.tag   = bus.m_axis_tuser[15:0];
        o.dByte = bus.m_axis_tdata[7:0];
        o.busy  = busy;
        o.gid   = int'(grant_id);
        o.cyc   = cycle;
        obsLog.push_back(o);
      end

      @(posedge clk);
      if (aresetn && expValid && snapReady) begin
        if (expLast) begin
          mCnt[sel] = (mCnt[sel] + 1) % (1 << CW);
          mPtr      = (sel + 1) % NP;
          mLocked   = 0;
          mGid      = sel;
        end else if (mLocked == 0) begin
          mLocked = 1;
          mOwner  = sel;
          mGid    = sel;
        end
      end
    end
  end

  initial begin
    logic [15:0] expTags [$];
    int n;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    #2 aresetn = 1'b1;
    @(negedge clk); #2;
    checkOutput("rst_grant_id", DW'(grant_id), DW'(0));
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));

    $display("[TB] scenario 1: single 4-beat packet on port 0");
    obsLog.delete();
    applyStimulus(0, 4, 0, -1, 0, 8'hFF);
    waitDrain("t1", 50);
    expTags = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    checkTags("t1", expTags);
    if (obsLog.size() == 4) begin
      checkOutput("t1_byte0", DW'(obsLog[0].dByte), DW'(8'hFF));
      checkOutput("t1_byte1", DW'(obsLog[1].dByte), DW'(8'hEF));
      checkOutput("t1_byte2", DW'(obsLog[2].dByte), DW'(8'hDF));
      checkOutput("t1_byte3", DW'(obsLog[3].dByte), DW'(8'hCF));
      checkOutput("t1_busy0", DW'(obsLog[0].busy), DW'(0));
      checkOutput("t1_busy3", DW'(obsLog[3].busy), DW'(1));
      checkOutput("t1_span", DW'(obsLog[3].cyc - obsLog[0].cyc), DW'(3));
    end
    checkOutput("t1_cnt", DW'(pkt_cnt), DW'(16'h0001));

    $display("[TB] scenario 2: ports 0 and 2 contend");
    doReset();
    applyStimulus(0, 3, 0, -1, 0, 8'h30);
    applyStimulus(2, 3, 0, -1, 0, 8'h90);
    waitDrain("t2", 50);
    expTags = '{16'h0000, 16'h0001, 16'h0002, 16'h0200, 16'h0201, 16'h0202};
    checkTags("t2", expTags);
    if (obsLog.size() == 6) begin
      checkOutput("t2_no_bubble", DW'(obsLog[5].cyc - obsLog[0].cyc), DW'(5));
      checkOutput("t2_gid_p0", DW'(obsLog[1].gid), DW'(0));
      checkOutput("t2_gid_p2", DW'(obsLog[4].gid), DW'(2));
    end
    checkOutput("t2_cnt", DW'(pkt_cnt), DW'(16'h0101));

    $display("[TB] scenario 3: downstream stall on beat 2 of port 1");
    doReset();
    readySched = '{1'b1, 1'b0, 1'b0, 1'b0};
    applyStimulus(1, 3, 0, -1, 0, 8'h70);
    waitDrain("t3", 50);
    expTags = '{16'h0100, 16'h0101, 16'h0102};
    checkTags("t3", expTags);
    if (obsLog.size() == 3) begin
      checkOutput("t3_stall_len", DW'(obsLog[1].cyc - obsLog[0].cyc), DW'(4));
      checkOutput("t3_after_stall", DW'(obsLog[2].cyc - obsLog[1].cyc), DW'(1));
    end
    checkOutput("t3_cnt", DW'(pkt_cnt), DW'(16'h0010));

    $display("[TB] scenario 4: valid gap on locked port 1 while port 3 waits");
    doReset();
    applyStimulus(1, 3, 0, 1, 2, 8'h60);
    applyStimulus(3, 2, 0, -1, 0, 8'hB0);
    waitDrain("t4", 50);
    expTags = '{16'h0100, 16'h0101, 16'h0102, 16'h0300, 16'h0301};
    checkTags("t4", expTags);
    if (obsLog.size() == 5) checkOutput("t4_gap", DW'(obsLog[1].cyc - obsLog[0].cyc), DW'(3));
    checkOutput("t4_cnt", DW'(pkt_cnt), DW'(16'h1010));

    $display("[TB] scenario 5: all ports stream single-beat packets");
    doReset();
    for (int p = 0; p < NP; p++) begin
      applyStimulus(p, 1, 0, -1, 0, 8'h11);
      applyStimulus(p, 1, 1, -1, 0, 8'h22);
    end
    waitDrain("t5", 50);
    expTags = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0010, 16'h0110, 16'h0210, 16'h0310};
    checkTags("t5", expTags);
    if (obsLog.size() == 8) checkOutput("t5_span", DW'(obsLog[7].cyc - obsLog[0].cyc), DW'(7));
    checkOutput("t5_cnt", DW'(pkt_cnt), DW'(16'h2222));

    $display("[TB] scenario 6: reset during beat 2 of a port 2 packet");
    obsLog.delete();
    applyStimulus(2, 1, 0, -1, 0, 8'h44);
    applyStimulus(2, 3, 1, -1, 0, 8'h55);
    n = 0;
    while (obsLog.size() < 2 && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    expTags = '{16'h0200, 16'h0210};
    checkTags("t6_pre", expTags);
    @(posedge clk); #3;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_rst_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
    checkOutput("t6_rst_tready", DW'(bus.s_axis_tready), DW'(0));
    checkOutput("t6_rst_cnt", DW'(pkt_cnt), DW'(0));
    checkOutput("t6_rst_busy", DW'(busy), DW'(0));
    repeat (2) @(negedge clk);
    #2 aresetn = 1'b1;
    obsLog.delete();
    applyStimulus(1, 2, 0, -1, 0, 8'h12);
    applyStimulus(3, 2, 0, -1, 0, 8'h34);
    waitDrain("t6", 50);
    expTags = '{16'h0100, 16'h0101, 16'h0300, 16'h0301};
    checkTags("t6_post", expTags);
    checkOutput("t6_cnt", DW'(pkt_cnt), DW'(16'h1010));

    $display("[TB] scenario 7: counter wrap on port 0");
    doReset();
    for (int k = 0; k < 17; k++) applyStimulus(0, 1, k, -1, 0, 8'h0F);
    waitDrain("t7", 80);
    checkOutput("t7_nbeats", DW'(obsLog.size()), DW'(17));
    checkOutput("t7_cnt_wrap", DW'(pkt_cnt), DW'(16'h0001));

    repeat (2) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
